serial_frame_deserializer: RTL and testbench
============================================

// Module: serial_frame_deserializer
// PURPOSE
//   Collects a UART-style serial bit stream into WIDTH-bit parallel words.
//   Presents each word on x with a valid/ready handshake.
//   Sits directly upstream of the ones-count encoder; x feeds the encoder's 7-bit input.
//   Flags parity, framing and overrun errors.
// PARAMETERS
//   WIDTH      7   data bits per frame (encoder input width)
//   PARITY_EN  1   1 = one even-parity bit after the data; 0 = no parity bit
// PORTS
//   clk         in   1      single system clock, rising edge
//   rst_n       in   1      asynchronous, active-low reset
//   bit_valid   in   1      strobe: serial_in is sampled this cycle
//   serial_in   in   1      serial data bit
//   x           out  WIDTH  assembled word, LSB = first data bit received
//   x_valid     out  1      x holds a complete frame
//   x_ready     in   1      consumer accepts x this cycle
//   parity_err  out  1      parity result of the word on x; meaningful only while x_valid
//   frame_err   out  1      sticky: bad stop bit seen
//   overrun     out  1      sticky: start bit arrived while a word was waiting
//   clr_err     in   1      synchronous clear of frame_err and overrun
//   busy        out  1      high in any state other than IDLE
// BEHAVIOUR
// Reset
//   - Reset is asynchronous and active-low.
//   - rst_n=0 forces: state IDLE, x=0, x_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0,
//     bit counter 0, parity accumulator 0.
//   - Reset asserted mid-frame or mid-hold discards the frame. No output pulses.
// Sampling
//   - All serial sampling happens only on cycles with bit_valid=1.
//   - Cycles with bit_valid=0 leave the state and datapath unchanged.
// FSM states
//   - IDLE: bit_valid and serial_in=0 (start bit) -> DATA, clear counter and parity.
//     serial_in=1 is idle-line; stay in IDLE.
//   - DATA: each bit_valid shifts serial_in into bit[cnt], LSB first, and XORs it into parity.
//     After WIDTH bits: go to PAR if PARITY_EN, else STOP.
//   - PAR: one bit_valid XORs serial_in into parity, then go to STOP.
//     Even parity: total ones over data+parity must be even.
//   - STOP: on bit_valid, serial_in=1 -> latch word into x, set parity_err = (parity!=0),
//     set x_valid=1 on the next edge, go to HOLD.
//     serial_in=0 -> set frame_err, discard the word, go to IDLE. x and x_valid are untouched.
//   - HOLD: x, x_valid and parity_err are held stable.
//     x_valid && x_ready -> transfer; next cycle x_valid=0 and state IDLE.
//     While in HOLD, bit_valid with serial_in=0 sets overrun; the bit is otherwise ignored.
// Timing
//   - Latency: x_valid rises the cycle after the clock edge that samples a good stop bit.
//   - At most one word is in flight. No skid buffer.
//   - A start bit on the same cycle as the HOLD transfer sets overrun and is dropped.
//     It is not accepted.
// Errors
//   - clr_err=1 clears frame_err and overrun on the next edge.
//   - If clr_err and a new error occur in the same cycle, the set wins.
//   - parity_err is forced to 0 when PARITY_EN=0.
// Widths
//   - Bit counter is $clog2(WIDTH+1) bits. It never exceeds WIDTH-1 in DATA.
// TESTING
//   - Reset: hold rst_n=0 mid-DATA -> all outputs 0.
//     Release, then send a clean frame -> correct word. No stale bits.
//   - Frame: start 0, data 1,0,1,1,0,0,1, parity 0, stop 1 -> x=7'b1001101, x_valid=1,
//     parity_err=0, one cycle after the stop sample.
//   - Parity: same data with parity bit 1 -> x=7'b1001101, parity_err=1.
//     All-ones data 7'h7F with parity 1 -> parity_err=0.
//   - Framing: good data and parity, stop bit 0 -> frame_err=1, x_valid stays 0.
//     Pulse clr_err -> frame_err=0.
//   - Backpressure/overrun: x_ready=0 for 20 cycles with a start bit arriving in HOLD
//     -> overrun=1, x unchanged.
//     x_ready=1 -> x_valid=0 next cycle; a following frame is received normally.
//   - Gaps: insert random bit_valid=0 cycles between bits; PARITY_EN=0 build
//     -> identical x; parity_err=0.

Source files
------------

// File: rtl/serial_frame_deserializer.sv
// serial_frame_deserializer
// Assembles a UART-style serial stream (start bit 0, WIDTH data bits LSB first,
// optional even-parity bit, stop bit 1) into a parallel word. The word is
// offered on x with a valid/ready handshake and is held until it is accepted.
// Parity, framing and overrun errors are reported alongside the word.
module serial_frame_deserializer #(
  parameter int WIDTH     = 7,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_valid,
  input  logic             serial_in,
  output logic [WIDTH-1:0] x,
  output logic             x_valid,
  input  logic             x_ready,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun,
  input  logic             clr_err,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PAR,
    S_STOP,
    S_HOLD
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] shift_q;
  logic             par_q;
  logic [WIDTH-1:0] x_q;
  logic             x_valid_q;
  logic             parity_err_q;
  logic             frame_err_q;
  logic             frame_err_d;
  logic             overrun_q;
  logic             overrun_d;
  logic             data_we;

  // Sticky error flags: a new error on the same cycle as clr_err wins over the clear.
  always_comb begin
    frame_err_d = frame_err_q & ~clr_err;
    overrun_d   = overrun_q & ~clr_err;
    if ((state_q == S_STOP) && bit_valid && !serial_in) begin
      frame_err_d = 1'b1;
    end
    if ((state_q == S_HOLD) && bit_valid && !serial_in) begin
      overrun_d = 1'b1;
    end
  end

  assign data_we = (state_q == S_DATA) && bit_valid;

  // Data bits land at the position given by the bit counter, so bit 0 is the first one received.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    // Capture this data bit when the counter points at it.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        shift_q[gi] <= 1'b0;
      end else if (data_we && (cnt_q == CNT_W'(gi))) begin
        shift_q[gi] <= serial_in;
      end
    end
  end

  // Frame FSM with the registered output word, handshake and error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      par_q        <= 1'b0;
      x_q          <= '0;
      x_valid_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      case (state_q)
        S_IDLE: begin
          // A 1 on the line is idle; only a 0 starts a frame.
          if (bit_valid && !serial_in) begin
            state_q <= S_DATA;
            cnt_q   <= '0;
            par_q   <= 1'b0;
          end
        end
        S_DATA: begin
          if (bit_valid) begin
            par_q <= par_q ^ serial_in;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              cnt_q   <= '0;
              state_q <= PARITY_EN ? S_PAR : S_STOP;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        S_PAR: begin
          if (bit_valid) begin
            par_q   <= par_q ^ serial_in;
            state_q <= S_STOP;
          end
        end
        S_STOP: begin
          if (bit_valid) begin
            if (serial_in) begin
              x_q          <= shift_q;
              parity_err_q <= PARITY_EN ? par_q : 1'b0;
              x_valid_q    <= 1'b1;
              state_q      <= S_HOLD;
            end else begin
              // Bad stop bit: drop the word, leave the presented word alone.
              state_q <= S_IDLE;
            end
          end
        end
        S_HOLD: begin
          // Serial bits are ignored here apart from the overrun flag.
          if (x_ready) begin
            x_valid_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign x          = x_q;
  assign x_valid    = x_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Testbench for serial_frame_deserializer: one instance with parity, one without.
// Stimulus pushes the expected word into a scoreboard queue; a monitor pops and
// compares whenever an instance presents a word.
module tb_serial_frame_deserializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] bv;
  logic [1:0] si;
  logic       xr;
  logic       clr;
  logic [6:0] xo [2];
  logic [1:0] xv, pe, fe, ov, bz;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       inst;
    logic       pe;
    logic [6:0] x;
  } exp_t;

  exp_t       sb_q[$];
  logic [1:0] seen;
  exp_t       cur [2];

  always #5 clk = ~clk;

  serial_frame_deserializer #(.WIDTH(7), .PARITY_EN(1'b1)) dut_p (
    .clk(clk), .rst_n(rst_n), .bit_valid(bv[0]), .serial_in(si[0]),
    .x(xo[0]), .x_valid(xv[0]), .x_ready(xr), .parity_err(pe[0]),
    .frame_err(fe[0]), .overrun(ov[0]), .clr_err(clr), .busy(bz[0])
  );

  serial_frame_deserializer #(.WIDTH(7), .PARITY_EN(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .bit_valid(bv[1]), .serial_in(si[1]),
    .x(xo[1]), .x_valid(xv[1]), .x_ready(xr), .parity_err(pe[1]),
    .frame_err(fe[1]), .overrun(ov[1]), .clr_err(clr), .busy(bz[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input int k, input string tag);
    chk({tag, "_x"}, 32'(xo[k]), 0);
    chk({tag, "_x_valid"}, 32'(xv[k]), 0);
    chk({tag, "_parity_err"}, 32'(pe[k]), 0);
    chk({tag, "_frame_err"}, 32'(fe[k]), 0);
    chk({tag, "_overrun"}, 32'(ov[k]), 0);
    chk({tag, "_busy"}, 32'(bz[k]), 0);
  endtask

  // Drive one sampled bit, optionally preceded by random bit_valid=0 cycles.
  task automatic send_bit(input int k, input logic b, input bit gaps);
    if (gaps) begin
      int n = $urandom_range(0, 3);
      repeat (n) begin
        si[k] = 1'($urandom);
        @(negedge clk);
      end
    end
    bv[k] = 1'b1;
    si[k] = b;
    @(negedge clk);
    bv[k] = 1'b0;
    si[k] = 1'($urandom);
  endtask

  // Whole frame; a good stop bit queues the expected word first.
  task automatic send_frame(input int k, input logic [6:0] data, input logic pbit,
                            input logic stop, input bit gaps);
    exp_t e;
    @(negedge clk);
    if (gaps) begin
      int n = $urandom_range(0, 2);
      repeat (n) send_bit(k, 1'b1, 1'b0);
    end
    send_bit(k, 1'b0, gaps);
    for (int i = 0; i < 7; i++) send_bit(k, data[i], gaps);
    if (k == 0) send_bit(k, pbit, gaps);
    if (stop) begin
      e.inst = 1'(k);
      // Even parity: error when data ones plus the parity bit is odd.
      e.pe   = (k == 0) ? 1'(($countones(data) + int'(pbit)) % 2) : 1'b0;
      e.x    = data;
      sb_q.push_back(e);
    end
    send_bit(k, stop, gaps);
    $display("frame inst=%0d data=%02h pbit=%0d stop=%0d", k, data, pbit, stop);
  endtask

  // Good frame with x_ready=1: valid right after the stop sample, gone one cycle later.
  task automatic good_frame(input int k, input logic [6:0] data, input logic pbit, input bit gaps);
    send_frame(k, data, pbit, 1'b1, gaps);
    chk("latency_x_valid", 32'(xv[k]), 1);
    @(negedge clk);
    chk("transfer_x_valid_low", 32'(xv[k]), 0);
    chk("transfer_busy_low", 32'(bz[k]), 0);
  endtask

  task automatic pulse_clr;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Scoreboard monitor: a rising x_valid pops the next expected word; while held, x must not move.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        seen[k] = 1'b0;
      end else if (xv[k]) begin
        if (!seen[k]) begin
          seen[k] = 1'b1;
          if (sb_q.size() == 0 || sb_q[0].inst != 1'(k)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word inst=%0d: got x=%02h, required no word", k, xo[k]);
            cur[k].inst = 1'(k);
            cur[k].pe   = pe[k];
            cur[k].x    = xo[k];
          end else begin
            cur[k] = sb_q.pop_front();
            chk("word_x", 32'(xo[k]), 32'(cur[k].x));
            chk("word_parity_err", 32'(pe[k]), 32'(cur[k].pe));
          end
        end else begin
          chk("hold_x_stable", 32'(xo[k]), 32'(cur[k].x));
          chk("hold_parity_err_stable", 32'(pe[k]), 32'(cur[k].pe));
        end
      end else begin
        seen[k] = 1'b0;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bv    = '0;
    si    = '1;
    xr    = 1'b1;
    clr   = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero(0, "reset_p");
    chk_zero(1, "reset_n");
    rst_n = 1'b1;

    // Directed frames
    good_frame(0, 7'b1001101, 1'b0, 1'b0);
    good_frame(0, 7'b1001101, 1'b1, 1'b0);
    good_frame(0, 7'h7F, 1'b1, 1'b0);

    // Reset in the middle of DATA
    send_bit(0, 1'b0, 1'b0);
    send_bit(0, 1'b1, 1'b0);
    send_bit(0, 1'b1, 1'b0);
    chk("mid_data_busy", 32'(bz[0]), 1);
    rst_n = 1'b0;
    #1;
    chk_zero(0, "async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    good_frame(0, 7'h2A, 1'b1, 1'b0);

    // Framing error and clear
    send_frame(0, 7'b1001101, 1'b0, 1'b0, 1'b0);
    chk("frame_err_set", 32'(fe[0]), 1);
    chk("frame_err_no_valid", 32'(xv[0]), 0);
    chk("frame_err_idle", 32'(bz[0]), 0);
    pulse_clr();
    chk("frame_err_cleared", 32'(fe[0]), 0);

    // Backpressure with a start bit arriving in HOLD
    xr = 1'b0;
    send_frame(0, 7'(($urandom)), 1'($urandom), 1'b1, 1'b0);
    chk("bp_x_valid", 32'(xv[0]), 1);
    repeat (4) @(negedge clk);
    send_bit(0, 1'b1, 1'b0);
    chk("bp_idle_bit_no_overrun", 32'(ov[0]), 0);
    send_bit(0, 1'b0, 1'b0);
    chk("bp_overrun_set", 32'(ov[0]), 1);
    chk("bp_still_busy", 32'(bz[0]), 1);
    chk("bp_still_valid", 32'(xv[0]), 1);
    repeat (13) @(negedge clk);
    xr = 1'b1;
    @(negedge clk);
    chk("bp_release_x_valid", 32'(xv[0]), 0);
    chk("bp_release_busy", 32'(bz[0]), 0);
    chk("bp_overrun_sticky", 32'(ov[0]), 1);
    pulse_clr();
    chk("overrun_cleared", 32'(ov[0]), 0);
    good_frame(0, 7'h55, 1'b0, 1'b0);

    // Start bit on the same cycle as the transfer is dropped
    xr = 1'b0;
    send_frame(0, 7'h13, 1'b1, 1'b1, 1'b0);
    chk("xfer_start_x_valid", 32'(xv[0]), 1);
    xr    = 1'b1;
    bv[0] = 1'b1;
    si[0] = 1'b0;
    @(negedge clk);
    bv[0] = 1'b0;
    chk("xfer_start_x_valid_low", 32'(xv[0]), 0);
    chk("xfer_start_overrun", 32'(ov[0]), 1);
    chk("xfer_start_not_accepted", 32'(bz[0]), 0);
    pulse_clr();

    // clr_err and a new overrun on the same cycle: the set wins
    xr = 1'b0;
    send_frame(0, 7'h66, 1'b0, 1'b1, 1'b0);
    clr   = 1'b1;
    bv[0] = 1'b1;
    si[0] = 1'b0;
    @(negedge clk);
    clr   = 1'b0;
    bv[0] = 1'b0;
    chk("set_wins_overrun", 32'(ov[0]), 1);
    xr = 1'b1;
    @(negedge clk);
    chk("set_wins_transfer", 32'(xv[0]), 0);
    pulse_clr();
    chk("set_wins_cleared", 32'(ov[0]), 0);

    // Random frames with gaps, parity instance
    for (int i = 0; i < 25; i++) begin
      logic [6:0] d;
      logic       p;
      d = 7'($urandom);
      p = 1'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        send_frame(0, d, p, 1'b0, 1'b1);
        chk("rand_frame_err", 32'(fe[0]), 1);
        chk("rand_frame_err_no_valid", 32'(xv[0]), 0);
        pulse_clr();
      end else begin
        good_frame(0, d, p, 1'b1);
      end
    end

    // No-parity instance: same word as the directed frame, then random
    good_frame(1, 7'b1001101, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) begin
      good_frame(1, 7'($urandom), 1'b0, 1'b1);
    end
    chk("nopar_no_errors", 32'({fe[1], ov[1]}), 0);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
